// File: rtl/eth_tx_arb_pkg.sv
// Shared types and defaults for the Ethernet TX arbiter and its round-robin picker.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam int ETH_MAX_FRAME = 1518;
    localparam int ETH_IFG       = 12;
    localparam int STATS_W       = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request after last_grant, wrapping.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant,
    output logic          any
);

    always_comb begin
        int idx;
        grant = last_grant;
        any   = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!any && req[IW'(idx)]) begin
                grant = IW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the MAC TX stream, with IFG insertion
// and oversize truncation. Define ETH_TX_ARB_STATS_EN to add frame/truncation counters.
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int DATA_W          = 8,
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME,
    parameter int IFG_BYTES       = ETH_IFG
) (
    input  logic                          pll_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_W-1:0]             tx_data,
    output logic                          tx_last,
    input  logic                          tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          busy,
    output logic                          trunc_err
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_W-1:0]    frame_cnt,
    output logic [STATS_W-1:0]            trunc_cnt
`endif
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int GCW = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
    localparam logic [BCW-1:0] BYTE_LIMIT = BCW'(MAX_FRAME_BYTES);
    localparam logic [GCW-1:0] GAP_END    = GCW'(IFG_BYTES - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FWD   = FWD;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_GAP   = GAP;

    logic [1:0]        state;
    logic [IW-1:0]     last_grant;
    logic [BCW-1:0]    byte_cnt;
    logic [GCW-1:0]    gap_cnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              in_fwd;
    logic [BCW-1:0]    byte_next;
    logic              at_limit;
    logic              fwd_xfer;
    logic              drain_end;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_fwd    = (state == ST_FWD);
    assign byte_next = byte_cnt + 1'b1;
    assign at_limit  = (byte_next == BYTE_LIMIT);
    assign fwd_xfer  = in_fwd && sel_valid && tx_ready;
    assign drain_end = (state == ST_DRAIN) && sel_valid && sel_last;

    // tx_last is forced on the byte that reaches the limit, even while stalled on it.
    assign tx_valid  = in_fwd && sel_valid;
    assign tx_data   = in_fwd ? sel_data : '0;
    assign tx_last   = tx_valid && (sel_last || at_limit);
    assign trunc_err = fwd_xfer && !sel_last && at_limit;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                if (in_fwd) begin
                    req_ready[i] = tx_ready;
                end else if (state == ST_DRAIN) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            byte_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_idx  <= pick_idx;
                        last_grant <= pick_idx;
                        byte_cnt   <= '0;
                        state      <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (fwd_xfer) begin
                        byte_cnt <= byte_next;
                        if (sel_last) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else if (at_limit) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_end) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_END) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    // A frame counts as completed when the arbiter enters GAP, truncated or not.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            trunc_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (((fwd_xfer && sel_last) || drain_end) && grant_idx == IW'(i)) begin
                    frame_cnt[i*STATS_W +: STATS_W] <= frame_cnt[i*STATS_W +: STATS_W] + 1'b1;
                end
            end
            if (trunc_err) begin
                trunc_cnt <= trunc_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: frame-level round-robin model plus directed scenarios.
module tb_eth_tx_arbiter;

    localparam int NREQ = 2;
    localparam int MAXB = 4;
    localparam int IFG  = 12;

    logic        pll_clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_ready;
    logic [0:0]  grant_idx;
    logic        busy;
    logic        trunc_err;
`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] trunc_cnt;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         grant;
        logic       trunc;
    } beat_t;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [8:0] src_q [NREQ][$];
    int         pend [NREQ][$];
    int         fr_base [64];
    int         fr_step [64];
    int         fr_len [64];
    int         nframes = 0;
    beat_t      exp_q [$];
    beat_t      log_q [$];
    int         mlast = NREQ - 1;
    int         model_frames [NREQ];
    int         model_trunc = 0;
    int         gap_left = 0;
    bit         want_idle = 1'b0;
    int         trunc_seen = 0;
    int         gap_obs = 0;
    logic [1:0] hs = '0;
    int         rdy_mode = 0;
    logic       rdy_phase = 1'b0;

    always #5 pll_clk = ~pll_clk;

    eth_tx_arbiter #(
        .NUM_REQ         (NREQ),
        .DATA_W          (8),
        .MAX_FRAME_BYTES (MAXB),
        .IFG_BYTES       (IFG)
    ) dut (
        .pll_clk   (pll_clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .grant_idx (grant_idx),
        .busy      (busy),
        .trunc_err (trunc_err)
`ifdef ETH_TX_ARB_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .trunc_cnt (trunc_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        tests_run++;
        if (act !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic loadFrame(input int r, input int base, input int step, input int len);
        int id;
        id = nframes;
        nframes++;
        fr_base[id] = base;
        fr_step[id] = step;
        fr_len[id]  = len;
        for (int k = 0; k < len; k++) begin
            src_q[r].push_back({(k == len - 1), 8'(base + step * k)});
        end
        pend[r].push_back(id);
    endtask

    // Frame-level round robin: whoever has a pending frame after the previous winner goes next.
    task automatic buildExpected();
        int    r;
        int    id;
        int    n;
        beat_t b;
        while (pend[0].size() + pend[1].size() > 0) begin
            r = mlast;
            do r = (r + 1) % NREQ; while (pend[r].size() == 0);
            id = pend[r].pop_front();
            mlast = r;
            n = (fr_len[id] > MAXB) ? MAXB : fr_len[id];
            for (int k = 0; k < n; k++) begin
                b.data  = 8'(fr_base[id] + fr_step[id] * k);
                b.last  = (k == n - 1);
                b.grant = r;
                b.trunc = (k == n - 1) && (fr_len[id] > MAXB);
                exp_q.push_back(b);
            end
            model_frames[r]++;
            if (fr_len[id] > MAXB) model_trunc++;
        end
    endtask

    task automatic driveInputs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        rdy_phase = ~rdy_phase;
        tx_ready  = (rdy_mode == 0) ? 1'b1 : rdy_phase;
    endtask

    task automatic sampleCycle();
        @(negedge pll_clk);
        #2;
        hs = req_valid & req_ready;
        if (busy && !tx_valid) gap_obs++;
    endtask

    task automatic advanceCycle();
        @(posedge pll_clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        driveInputs();
    endtask

    task automatic applyStimulus();
        sampleCycle();
        advanceCycle();
    endtask

    task automatic runUntilDone(input int budget, input string name);
        int c;
        bit done;
        c = 0;
        done = 1'b0;
        while (!done && c < budget) begin
            applyStimulus();
            c++;
            done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (exp_q.size() == 0) &&
                   !busy && (gap_left == 0) && !want_idle;
        end
        if (!done) checkOutput({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic startTest();
        log_q.delete();
        trunc_seen = 0;
        gap_obs    = 0;
    endtask

    always @(negedge pll_clk) begin
        beat_t e;
        beat_t a;
        if (!rst_n) begin
            gap_left  = 0;
            want_idle = 1'b0;
        end else begin
            if (gap_left > 0) begin
                checkOutput("gap_tx_valid", {31'b0, tx_valid}, 32'd0);
                checkOutput("gap_req_ready", {30'b0, req_ready}, 32'd0);
                checkOutput("gap_busy", {31'b0, busy}, 32'd1);
                gap_left--;
                if (gap_left == 0) want_idle = 1'b1;
            end else if (want_idle) begin
                checkOutput("idle_after_gap", {31'b0, busy}, 32'd0);
                want_idle = 1'b0;
            end
            checkOutput("tx_last_without_valid", {31'b0, tx_last & ~tx_valid}, 32'd0);
            checkOutput("req_ready_onehot", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("tx_valid_unexpected", {31'b0, tx_valid}, 32'd0);
                end else begin
                    e = exp_q[0];
                    checkOutput("tx_data", {24'b0, tx_data}, {24'b0, e.data});
                    checkOutput("tx_last", {31'b0, tx_last}, {31'b0, e.last});
                    checkOutput("grant_idx", {31'b0, grant_idx}, e.grant);
                    checkOutput("req_ready_fwd", {30'b0, req_ready}, tx_ready ? (32'd1 << e.grant) : 32'd0);
                    if (tx_ready) begin
                        checkOutput("trunc_err", {31'b0, trunc_err}, {31'b0, e.trunc});
                        a.data  = tx_data;
                        a.last  = tx_last;
                        a.grant = int'(grant_idx);
                        a.trunc = trunc_err;
                        log_q.push_back(a);
                        void'(exp_q.pop_front());
                    end else begin
                        checkOutput("trunc_err_stalled", {31'b0, trunc_err}, 32'd0);
                    end
                end
            end else begin
                checkOutput("trunc_err_no_valid", {31'b0, trunc_err}, 32'd0);
            end
            if (trunc_err) trunc_seen++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i] && req_last[i]) gap_left = IFG;
            end
        end
    end

    initial begin
        bit found;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        model_frames[0] = 0;
        model_frames[1] = 0;
        #12;
        checkOutput("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("reset_tx_last", {31'b0, tx_last}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_grant_idx", {31'b0, grant_idx}, 32'd0);
        checkOutput("reset_req_ready", {30'b0, req_ready}, 32'd0);
        @(posedge pll_clk);
        #1;
        rst_n = 1'b1;
        driveInputs();

        // Single 3-byte frame from requester 0, then the 12-cycle gap.
        startTest();
        loadFrame(0, 'hAA, 'h11, 3);
        buildExpected();
        driveInputs();
        runUntilDone(100, "t1");
        checkOutput("t1_len", log_q.size(), 32'd3);
        if (log_q.size() == 3) begin
            checkOutput("t1_b0", {24'b0, log_q[0].data}, 32'hAA);
            checkOutput("t1_b1", {24'b0, log_q[1].data}, 32'hBB);
            checkOutput("t1_b2", {24'b0, log_q[2].data}, 32'hCC);
            checkOutput("t1_last1", {31'b0, log_q[1].last}, 32'd0);
            checkOutput("t1_last2", {31'b0, log_q[2].last}, 32'd1);
        end
        checkOutput("t1_gap_cycles", gap_obs, 32'd12);
        checkOutput("t1_grant_after", {31'b0, grant_idx}, 32'd0);

        // Requester 1 frame of exactly the size limit, MAC ready toggling.
        startTest();
        rdy_mode = 1;
        loadFrame(1, 'h21, 1, 4);
        buildExpected();
        driveInputs();
        runUntilDone(100, "t2");
        rdy_mode = 0;
        checkOutput("t2_len", log_q.size(), 32'd4);
        if (log_q.size() == 4) begin
            checkOutput("t2_b2", {24'b0, log_q[2].data}, 32'h23);
            checkOutput("t2_b3", {24'b0, log_q[3].data}, 32'h24);
            checkOutput("t2_last3", {31'b0, log_q[3].last}, 32'd1);
            checkOutput("t2_grant", log_q[0].grant, 32'd1);
        end
        checkOutput("t2_no_trunc", trunc_seen, 32'd0);

        // Both requesters busy with two 2-byte frames each: grants alternate.
        startTest();
        loadFrame(0, 'h01, 1, 2);
        loadFrame(0, 'h03, 1, 2);
        loadFrame(1, 'h11, 1, 2);
        loadFrame(1, 'h13, 1, 2);
        buildExpected();
        driveInputs();
        runUntilDone(200, "t3");
        checkOutput("t3_len", log_q.size(), 32'd8);
        if (log_q.size() == 8) begin
            checkOutput("t3_g0", log_q[0].grant, 32'd0);
            checkOutput("t3_g1", log_q[2].grant, 32'd1);
            checkOutput("t3_g2", log_q[4].grant, 32'd0);
            checkOutput("t3_g3", log_q[6].grant, 32'd1);
            checkOutput("t3_d2", {24'b0, log_q[2].data}, 32'h11);
            checkOutput("t3_d5", {24'b0, log_q[5].data}, 32'h04);
        end

        // 7-byte frame from requester 0 against a 4-byte limit.
        startTest();
        loadFrame(0, 'h31, 1, 7);
        buildExpected();
        driveInputs();
        runUntilDone(100, "t4");
        checkOutput("t4_len", log_q.size(), 32'd4);
        if (log_q.size() == 4) begin
            checkOutput("t4_b3", {24'b0, log_q[3].data}, 32'h34);
            checkOutput("t4_last3", {31'b0, log_q[3].last}, 32'd1);
            checkOutput("t4_last2", {31'b0, log_q[2].last}, 32'd0);
        end
        checkOutput("t4_trunc_pulses", trunc_seen, 32'd1);

        // Single-byte frame.
        startTest();
        loadFrame(1, 'h5A, 1, 1);
        buildExpected();
        driveInputs();
        runUntilDone(100, "t5");
        checkOutput("t5_len", log_q.size(), 32'd1);
        if (log_q.size() == 1) begin
            checkOutput("t5_data", {24'b0, log_q[0].data}, 32'h5A);
            checkOutput("t5_last", {31'b0, log_q[0].last}, 32'd1);
        end

        // Asynchronous reset while the second byte of a frame is on the bus.
        startTest();
        loadFrame(0, 'h41, 1, 3);
        buildExpected();
        driveInputs();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            sampleCycle();
            if (tx_valid && tx_data == 8'h42) found = 1'b1;
            else advanceCycle();
        end
        checkOutput("t6_reached_byte2", {31'b0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_tx_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("t6_tx_last", {31'b0, tx_last}, 32'd0);
        checkOutput("t6_tx_data", {24'b0, tx_data}, 32'd0);
        checkOutput("t6_req_ready", {30'b0, req_ready}, 32'd0);
        checkOutput("t6_busy", {31'b0, busy}, 32'd0);
        checkOutput("t6_grant_idx", {31'b0, grant_idx}, 32'd0);
        src_q[0].delete();
        src_q[1].delete();
        pend[0].delete();
        pend[1].delete();
        exp_q.delete();
        hs = '0;
        mlast = NREQ - 1;
        model_frames[0] = 0;
        model_frames[1] = 0;
        model_trunc = 0;
        driveInputs();
        repeat (2) @(posedge pll_clk);
        #1;
        rst_n = 1'b1;

        // After reset: one oversize frame from req0 and three frames from req1.
        startTest();
        loadFrame(0, 'h61, 1, 7);
        loadFrame(1, 'h71, 1, 1);
        loadFrame(1, 'h72, 1, 2);
        loadFrame(1, 'h74, 1, 1);
        buildExpected();
        driveInputs();
        runUntilDone(300, "t7");
        checkOutput("t7_len", log_q.size(), 32'd8);
        if (log_q.size() == 8) begin
            checkOutput("t7_first_grant", log_q[0].grant, 32'd0);
            checkOutput("t7_first_data", {24'b0, log_q[0].data}, 32'h61);
            checkOutput("t7_g4", log_q[4].grant, 32'd1);
            checkOutput("t7_d6", {24'b0, log_q[6].data}, 32'h73);
        end
`ifdef ETH_TX_ARB_STATS_EN
        checkOutput("frame_cnt0", {16'b0, frame_cnt[15:0]}, model_frames[0]);
        checkOutput("frame_cnt1", {16'b0, frame_cnt[31:16]}, model_frames[1]);
        checkOutput("trunc_cnt", {16'b0, trunc_cnt}, model_trunc);
        checkOutput("frame_cnt0_lit", {16'b0, frame_cnt[15:0]}, 32'd1);
        checkOutput("frame_cnt1_lit", {16'b0, frame_cnt[31:16]}, 32'd3);
        checkOutput("trunc_cnt_lit", {16'b0, trunc_cnt}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Round-robin arbiter that shares the single Ethernet MAC TX byte stream inside the PipelineC Ethernet design between NUM_REQ frame sources, e.g. UART bridge, loopback and status beacon.
- Grants are frame-granular: the grant is held from the first byte until `last`.
- Enforces the minimum inter-frame gap and truncates oversize frames.
- Runs in the PLL clock domain, between the requester logic and the MAC TX.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, stream byte width.
- MAX_FRAME_BYTES, 1518, maximum bytes forwarded per frame before truncation.
- IFG_BYTES, 12, idle cycles inserted after each frame.

Ports:
- pll_clk  input  1  PLL clock; all logic is on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- req_valid  input  NUM_REQ  Per-requester byte valid.
- req_data  input  NUM_REQ*DATA_W  Per-requester data, packed; requester i occupies [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  Per-requester end-of-frame flag.
- req_ready  output  NUM_REQ  Per-requester ready.
- tx_valid  output  1  Stream valid to the MAC.
- tx_data  output  DATA_W  Stream data to the MAC.
- tx_last  output  1  End-of-frame flag to the MAC.
- tx_ready  input  1  MAC ready.
- grant_idx  output  $clog2(NUM_REQ)  Current or most recent grant index.
- busy  output  1  High in any state other than IDLE.
- trunc_err  output  1  One-cycle pulse when a frame is truncated.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = NUM_REQ-1, so requester 0 wins first; byte and gap counters 0.
- A transfer occurs on a cycle where valid && ready.
- States:
  - IDLE: if any req_valid, pick the first requester with valid, searching from last_grant+1 with wrap. Register grant_idx and last_grant, go to FWD. Arbitration costs one cycle. req_ready is all 0 and tx_valid is 0.
  - FWD: combinational pass-through of the granted requester, zero latency.
    - tx_valid = req_valid[g], tx_data = req_data[g], tx_ready drives req_ready[g]; all other req_ready are 0.
    - byte_cnt increments on each transfer.
    - On a transfer with req_last[g] set, go to GAP.
    - On the transfer that brings byte_cnt to MAX_FRAME_BYTES without last: force tx_last = 1, pulse trunc_err, go to DRAIN.
  - DRAIN: req_ready[g] = 1 and tx_valid = 0. Discard bytes until a transfer with req_last[g], then go to GAP.
  - GAP: tx_valid = 0 and all req_ready = 0 for exactly IFG_BYTES cycles, counted by gap_cnt, then go to IDLE.
- A requester whose valid drops mid-frame keeps the grant; the arbiter waits with no timeout.
- tx_last is only ever asserted together with tx_valid.
- A requester raising valid during FWD, DRAIN or GAP is considered only at the next IDLE.
- A single-byte frame (valid and last on the first byte) is legal: FWD lasts one transfer, then GAP.
- Counters are sized for MAX_FRAME_BYTES and IFG_BYTES; byte_cnt clears on entry to FWD.
- Async reset mid-frame returns to IDLE immediately. Outputs clear with no partial tx_last; the MAC handles the aborted frame.

Optional Feature:
- Macro: ETH_TX_ARB_STATS_EN.
- When defined, adds output frame_cnt (NUM_REQ*16) and output trunc_cnt (16).
  - frame_cnt: per-requester count of completed frames, incremented on entry to GAP; counts wrap.
  - trunc_cnt: count of truncated frames; counts wrap.
  - Both reset to 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package eth_tx_arb_pkg:
  - state enum: IDLE, FWD, DRAIN, GAP;
  - default constants ETH_MAX_FRAME = 1518 and ETH_IFG = 12;
  - stats counter width constant.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: request vector, last_grant.
  - Outputs: grant index, any-request flag.
  - Reused by future RX-side schedulers.

Test Plan:
- Reset, then req0 sends 3 bytes {AA,BB,CC} with last on CC and tx_ready = 1 → tx carries AA,BB,CC with tx_last on CC; then exactly 12 idle cycles; grant_idx = 0.
- req0 and req1 both valid continuously, 2-byte frames → grants alternate 0,1,0,1; no interleaving of bytes within a frame.
- tx_ready toggled 1,0,1,0 during a req1 frame → data held stable while stalled; req_ready[1] mirrors tx_ready; no byte lost or duplicated.
- MAX_FRAME_BYTES = 4, req0 sends 7 bytes → 4 bytes forwarded, tx_last on byte 4, trunc_err pulses once, remaining 3 bytes drained, then GAP.
- rst_n asserted on byte 2 of a frame → all outputs 0 asynchronously; after release, IDLE, and requester 0 wins first.
- With ETH_TX_ARB_STATS_EN: 3 frames from req1 plus 1 truncated frame from req0 → frame_cnt[1] = 3, frame_cnt[0] = 1, trunc_cnt = 1.
